// File: rtl/sys_clk_timer_scheduler.sv
// Shares one interval timer between REQ_N requesters. A round-robin arbiter
// picks an owner, the FSM programs the timer over a one-cycle-per-write bus,
// waits for the interrupt (or a cancel), acknowledges it and reports done.
//
// state    | meaning
// ---------+-----------------------------------------------
// IDLE     | no owner; arbitrate among pending requests
// W_STOP   | write control = STOP
// W_PLO    | write period[15:0]
// W_PHI    | write period[31:16]
// W_CLR    | clear status (drop any stale timeout flag)
// W_START  | write control = ITO | START, one-shot
// WAIT_IRQ | timer running; watch irq and owner's req
// W_ACK    | clear status after timeout
// DONE     | pulse done to owner, release grant
// A_STOP   | owner cancelled; stop the timer
// A_CLR    | owner cancelled; clear status
module sys_clk_timer_scheduler #(
  parameter int REQ_N = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [REQ_N-1:0]     req,
  input  logic [32*REQ_N-1:0]  delay,
  output logic [REQ_N-1:0]     grant,
  output logic [REQ_N-1:0]     done,
  output logic                 busy,
  output logic [2:0]           tmr_address,
  output logic                 tmr_chipselect,
  output logic                 tmr_write_n,
  output logic [15:0]          tmr_writedata,
  input  logic                 tmr_irq
);

  localparam int IW = (REQ_N > 1) ? $clog2(REQ_N) : 1;

  typedef enum logic [3:0] {
    IDLE, W_STOP, W_PLO, W_PHI, W_CLR, W_START,
    WAIT_IRQ, W_ACK, DONE, A_STOP, A_CLR
  } state_t;

  state_t            state, state_nxt;
  logic [IW-1:0]     owner, owner_nxt;
  logic [IW-1:0]     rr_ptr, rr_ptr_nxt;
  logic [IW-1:0]     win_idx;
  logic              win_found;
  logic [31:0]       win_delay;
  logic [31:0]       period, period_nxt;

  logic [REQ_N-1:0]  grant_nxt, done_nxt;
  logic              busy_nxt;
  logic [2:0]        addr_nxt;
  logic              cs_nxt;
  logic [15:0]       data_nxt;

  // Round-robin search: first pending request at or after rr_ptr.
  always_comb begin
    logic [IW:0] cand;
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 0; k < REQ_N; k++) begin
      cand = {1'b0, rr_ptr} + (IW+1)'(k);
      if (cand >= (IW+1)'(REQ_N))
        cand = cand - (IW+1)'(REQ_N);
      if (!win_found && req[cand[IW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IW-1:0];
      end
    end
  end

  // Select the winner's delay word.
  always_comb begin
    win_delay = '0;
    for (int i = 0; i < REQ_N; i++) begin
      if (win_idx == IW'(i))
        win_delay = delay[32*i +: 32];
    end
  end

  // Next state, owner, round-robin pointer and latched period.
  always_comb begin
    state_nxt  = state;
    owner_nxt  = owner;
    rr_ptr_nxt = rr_ptr;
    period_nxt = period;
    unique case (state)
      IDLE: begin
        if (win_found) begin
          state_nxt  = W_STOP;
          owner_nxt  = win_idx;
          rr_ptr_nxt = (win_idx == IW'(REQ_N-1)) ? '0 : win_idx + IW'(1);
          // delay 0 behaves like delay 1 so the period never wraps
          period_nxt = (win_delay == 32'd0) ? 32'd0 : win_delay - 32'd1;
        end
      end
      W_STOP:   state_nxt = W_PLO;
      W_PLO:    state_nxt = W_PHI;
      W_PHI:    state_nxt = W_CLR;
      W_CLR:    state_nxt = W_START;
      W_START:  state_nxt = WAIT_IRQ;
      WAIT_IRQ: begin
        // irq wins over a simultaneous cancel
        if (tmr_irq)
          state_nxt = W_ACK;
        else if (!req[owner])
          state_nxt = A_STOP;
      end
      W_ACK:    state_nxt = DONE;
      DONE:     state_nxt = IDLE;
      A_STOP:   state_nxt = A_CLR;
      A_CLR:    state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Output values for the state being entered, so outputs can be registered.
  always_comb begin
    addr_nxt  = 3'd0;
    cs_nxt    = 1'b0;
    data_nxt  = 16'h0000;
    done_nxt  = '0;
    grant_nxt = grant;
    busy_nxt  = (state_nxt != IDLE);
    if (state == IDLE && win_found)
      grant_nxt = REQ_N'(1) << win_idx;
    case (state_nxt)
      W_STOP, A_STOP: begin
        cs_nxt   = 1'b1;
        addr_nxt = 3'd1;
        data_nxt = 16'h0008;
      end
      W_PLO: begin
        cs_nxt   = 1'b1;
        addr_nxt = 3'd2;
        data_nxt = period[15:0];
      end
      W_PHI: begin
        cs_nxt   = 1'b1;
        addr_nxt = 3'd3;
        data_nxt = period[31:16];
      end
      W_CLR, W_ACK, A_CLR: begin
        cs_nxt   = 1'b1;
      end
      W_START: begin
        cs_nxt   = 1'b1;
        addr_nxt = 3'd1;
        data_nxt = 16'h0005;
      end
      DONE: begin
        done_nxt  = REQ_N'(1) << owner;
        grant_nxt = '0;
      end
      IDLE: begin
        grant_nxt = '0;
      end
      default: ;
    endcase
  end

  // State, context and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      owner          <= '0;
      rr_ptr         <= '0;
      period         <= '0;
      grant          <= '0;
      done           <= '0;
      busy           <= 1'b0;
      tmr_address    <= 3'd0;
      tmr_chipselect <= 1'b0;
      tmr_write_n    <= 1'b1;
      tmr_writedata  <= 16'h0000;
    end else begin
      state          <= state_nxt;
      owner          <= owner_nxt;
      rr_ptr         <= rr_ptr_nxt;
      period         <= period_nxt;
      grant          <= grant_nxt;
      done           <= done_nxt;
      busy           <= busy_nxt;
      tmr_address    <= addr_nxt;
      tmr_chipselect <= cs_nxt;
      tmr_write_n    <= ~cs_nxt;
      tmr_writedata  <= data_nxt;
    end
  end

endmodule

// File: tb/tb_sys_clk_timer_scheduler.sv
// Directed bench for sys_clk_timer_scheduler with a transaction-level model
// checked every cycle plus literal expectations per scenario.
module tb_sys_clk_timer_scheduler;

  localparam int N = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [N-1:0]  req = '0;
  logic [32*N-1:0] delay = '0;
  logic [N-1:0]  grant, done;
  logic          busy;
  logic [2:0]    tmr_address;
  logic          tmr_chipselect, tmr_write_n;
  logic [15:0]   tmr_writedata;
  logic          tmr_irq;
  logic          irq_man = 1'b0;
  logic          auto_irq = 1'b0;
  logic          irq_stub = 1'b0;

  assign tmr_irq = auto_irq ? irq_stub : irq_man;

  sys_clk_timer_scheduler #(.REQ_N(N)) dut (
    .clk(clk), .reset(reset), .req(req), .delay(delay),
    .grant(grant), .done(done), .busy(busy),
    .tmr_address(tmr_address), .tmr_chipselect(tmr_chipselect),
    .tmr_write_n(tmr_write_n), .tmr_writedata(tmr_writedata),
    .tmr_irq(tmr_irq)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(string nm, logic [31:0] a, logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, a, e, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  typedef struct packed {
    logic [3:0]  g;
    logic [3:0]  d;
    logic        b;
    logic [2:0]  a;
    logic [15:0] w;
    logic        cs;
    logic        wn;
  } rec_t;

  function automatic rec_t mk(logic [3:0] g, logic [3:0] d, logic b,
                              logic [2:0] a, logic [15:0] w, logic cs);
    rec_t r;
    r.g = g; r.d = d; r.b = b; r.a = a; r.w = w; r.cs = cs; r.wn = ~cs;
    return r;
  endfunction

  rec_t        exp_r = 30'h1;
  rec_t        mq[$];
  bit          m_wait;
  int          m_ptr, m_owner, m_win;
  logic [3:0]  m_g;
  logic [31:0] m_dl, m_per;

  // Each record is what the outputs must show for one cycle.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete();
      m_wait = 0; m_ptr = 0; m_owner = 0;
      exp_r = mk(0, 0, 0, 0, 0, 0);
    end else begin
      if (mq.size() == 0) begin
        if (!m_wait) begin
          m_win = -1;
          for (int k = 0; k < N; k++)
            if (m_win < 0 && req[(m_ptr + k) % N]) m_win = (m_ptr + k) % N;
          if (m_win >= 0) begin
            m_owner = m_win;
            m_ptr   = (m_win + 1) % N;
            m_g     = 4'b0001 << m_win;
            m_dl    = delay[32*m_win +: 32];
            m_per   = (m_dl == 0) ? 32'd0 : m_dl - 32'd1;
            mq.push_back(mk(m_g, 0, 1, 3'd1, 16'h0008, 1));
            mq.push_back(mk(m_g, 0, 1, 3'd2, m_per[15:0], 1));
            mq.push_back(mk(m_g, 0, 1, 3'd3, m_per[31:16], 1));
            mq.push_back(mk(m_g, 0, 1, 3'd0, 16'h0000, 1));
            mq.push_back(mk(m_g, 0, 1, 3'd1, 16'h0005, 1));
            mq.push_back(mk(m_g, 0, 1, 3'd0, 16'h0000, 0));
            m_wait = 1;
          end
        end else begin
          m_g = 4'b0001 << m_owner;
          if (tmr_irq) begin
            mq.push_back(mk(m_g, 0, 1, 3'd0, 16'h0000, 1));
            mq.push_back(mk(0, m_g, 1, 3'd0, 16'h0000, 0));
            mq.push_back(mk(0, 0, 0, 3'd0, 16'h0000, 0));
            m_wait = 0;
          end else if (!req[m_owner]) begin
            mq.push_back(mk(m_g, 0, 1, 3'd1, 16'h0008, 1));
            mq.push_back(mk(m_g, 0, 1, 3'd0, 16'h0000, 1));
            mq.push_back(mk(0, 0, 0, 3'd0, 16'h0000, 0));
            m_wait = 0;
          end else begin
            mq.push_back(mk(m_g, 0, 1, 3'd0, 16'h0000, 0));
          end
        end
      end
      if (mq.size() > 0) exp_r = mq.pop_front();
      else               exp_r = mk(0, 0, 0, 0, 0, 0);
    end
  end

  // Compare every cycle against the model.
  always @(negedge clk) begin
    chk("cycle_outputs",
        32'({grant, done, busy, tmr_address, tmr_writedata, tmr_chipselect, tmr_write_n}),
        32'(exp_r));
  end

  // ---------------- monitors and timer stub ----------------
  logic [18:0] wlog[$];
  logic [3:0]  gseq[$];
  logic [3:0]  prev_grant = '0;
  int          done_cnt = 0;
  int          stub_cnt = 0;

  always @(negedge clk) begin
    if (tmr_chipselect && !tmr_write_n) wlog.push_back({tmr_address, tmr_writedata});
    if (done != 0) done_cnt++;
    if (grant != 0 && prev_grant == 0) gseq.push_back(grant);
    prev_grant = grant;
  end

  // Raises irq a few cycles after a start write; cleared by a status write.
  always @(negedge clk) begin
    if (reset) begin
      stub_cnt = 0;
      irq_stub = 1'b0;
    end else if (tmr_chipselect && !tmr_write_n && tmr_address == 3'd1 && tmr_writedata == 16'h0005) begin
      stub_cnt = 4;
    end else if (tmr_chipselect && !tmr_write_n && tmr_address == 3'd0 && irq_stub) begin
      irq_stub = 1'b0;
    end else if (stub_cnt > 0) begin
      stub_cnt--;
      if (stub_cnt == 0) irq_stub = 1'b1;
    end
  end

  function automatic logic [18:0] wl(int i);
    if (i < wlog.size()) return wlog[i];
    return 19'h7FFFF;
  endfunction

  task automatic step(int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (busy && t < 300) begin
      step(1);
      t++;
    end
    chk("idle_reached", 32'(busy), 32'd0);
    step(2);
  endtask

  task automatic run_one(int idx, logic [31:0] dl, logic [15:0] lo, logic [15:0] hi);
    bit seen;
    auto_irq = 1'b1;
    delay[32*idx +: 32] = dl;
    wlog.delete();
    req = 4'b0001 << idx;
    seen = 0;
    for (int t = 0; t < 100 && !seen; t++) begin
      step(1);
      if (done[idx]) seen = 1;
    end
    req = '0;
    chk("per_done_seen", 32'(seen), 32'd1);
    chk("per_lo", 32'(wl(1)), 32'({3'd2, lo}));
    chk("per_hi", 32'(wl(2)), 32'({3'd3, hi}));
    chk("per_nwrites", 32'(wlog.size()), 32'd6);
    wait_idle();
    auto_irq = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1);
  end

  initial begin
    int n;
    int dc;
    logic [3:0] rr_exp [5];
    rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    // reset values
    step(2);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cs", 32'(tmr_chipselect), 32'd0);
    chk("rst_wn", 32'(tmr_write_n), 32'd1);
    reset = 1'b0;

    // round robin with all requesters held
    auto_irq = 1'b1;
    for (int i = 0; i < N; i++) delay[32*i +: 32] = 32'd3;
    req = 4'hF;
    for (int t = 0; t < 400 && gseq.size() < 5; t++) step(1);
    req = '0;
    chk("rr_count", 32'(gseq.size()), 32'd5);
    for (int i = 0; i < 5; i++)
      if (i < gseq.size()) chk("rr_order", 32'(gseq[i]), 32'(rr_exp[i]));
    wait_idle();
    auto_irq = 1'b0;

    // single request, delay 100, manual irq
    delay = '0;
    delay[31:0] = 32'd100;
    wlog.delete();
    req = 4'b0001;
    step(1);
    chk("s1_grant", 32'(grant), 32'h1);
    chk("s1_w_stop", 32'(wl(0)), 32'({3'd1, 16'h0008}));
    step(4);
    chk("s1_w_plo", 32'(wl(1)), 32'({3'd2, 16'h0063}));
    chk("s1_w_phi", 32'(wl(2)), 32'({3'd3, 16'h0000}));
    chk("s1_w_clr", 32'(wl(3)), 32'({3'd0, 16'h0000}));
    chk("s1_w_start", 32'(wl(4)), 32'({3'd1, 16'h0005}));
    chk("s1_nwrites", 32'(wlog.size()), 32'd5);
    step(3);
    irq_man = 1'b1;
    step(1);
    chk("s1_ack", 32'(wl(5)), 32'({3'd0, 16'h0000}));
    chk("s1_ack_grant", 32'(grant), 32'h1);
    chk("s1_no_done_yet", 32'(done), 32'h0);
    irq_man = 1'b0;
    step(1);
    chk("s1_done", 32'(done), 32'h1);
    chk("s1_done_grant", 32'(grant), 32'h0);
    req = '0;
    wait_idle();

    // period arithmetic
    run_one(1, 32'h0001_0000, 16'hFFFF, 16'h0000);
    run_one(2, 32'h0000_0000, 16'h0000, 16'h0000);
    run_one(3, 32'h0000_0001, 16'h0000, 16'h0000);
    run_one(0, 32'h1234_5678, 16'h5677, 16'h1234);

    // cancel in WAIT_IRQ, then arbitrate the other pending request
    for (int i = 0; i < N; i++) delay[32*i +: 32] = 32'd50;
    req = 4'b0101;
    step(8);
    chk("can_grant", 32'(grant), 32'h4);
    wlog.delete();
    dc = done_cnt;
    req = 4'b0001;
    step(1);
    chk("can_stop", 32'(wl(0)), 32'({3'd1, 16'h0008}));
    step(1);
    chk("can_clr", 32'(wl(1)), 32'({3'd0, 16'h0000}));
    step(1);
    chk("can_idle_grant", 32'(grant), 32'h0);
    step(1);
    chk("can_next_grant", 32'(grant), 32'h1);
    chk("can_no_done", 32'(done_cnt), 32'(dc));
    req = '0;
    wait_idle();

    // irq and req drop in the same cycle
    req = 4'b0010;
    delay[63:32] = 32'd20;
    step(8);
    chk("sim_grant", 32'(grant), 32'h2);
    wlog.delete();
    irq_man = 1'b1;
    req = '0;
    step(1);
    chk("sim_ack", 32'(wl(0)), 32'({3'd0, 16'h0000}));
    chk("sim_nwrites", 32'(wlog.size()), 32'd1);
    irq_man = 1'b0;
    step(1);
    chk("sim_done", 32'(done), 32'h2);
    wait_idle();

    // reset while writing period_h
    delay[31:0] = 32'd7;
    wlog.delete();
    req = 4'b0001;
    step(3);
    chk("rp_phi", 32'(wl(2)), 32'({3'd3, 16'h0000}));
    #2 reset = 1'b1;
    #1;
    chk("rp_grant", 32'(grant), 32'h0);
    chk("rp_busy", 32'(busy), 32'h0);
    chk("rp_cs", 32'(tmr_chipselect), 32'h0);
    chk("rp_wn", 32'(tmr_write_n), 32'h1);
    chk("rp_bus", 32'({tmr_address, tmr_writedata}), 32'h0);
    n = wlog.size();
    req = '0;
    step(3);
    reset = 1'b0;
    step(3);
    chk("rp_no_writes", 32'(wlog.size()), 32'(n));
    chk("rp_idle_busy", 32'(busy), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
